branch_seq_ctrl: RTL and testbench

Sequencing controller for branch and jump resolution in the RISC-V core's execute stage. It accepts one control-transfer request at a time from decode through a valid/ready handshake and evaluates the branch condition internally, using the same funct3 semantics as the core's branch comparator. For taken transfers it computes the target, drives a redirect handshake to fetch, and then holds a pipeline flush for a programmable number of cycles. It also produces the link write-back for jal/jalr, flags misaligned targets, and keeps branch statistics counters.

---
 rtl/branch_seq_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_branch_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: execute-stage sequencer for branches and jumps.
// Accepts one control-transfer request at a time, resolves it in a single
// evaluation cycle, redirects fetch for taken aligned targets and then holds
// a flush for FLUSH_CYCLES cycles. Also produces the jal/jalr link write-back,
// a misaligned-target pulse and conditional-branch statistics.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. req_ready is high only in IDLE; redir_valid is high only in
// REDIRECT and redir_pc is held constant until redir_ready is sampled high.
module branch_seq_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_pc,
    input  logic [31:0]      req_imm,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [31:0]      redir_pc,
    output logic             flush,
    output logic             link_valid,
    output logic [31:0]      link_data,
    output logic             misalign,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EVAL     = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    localparam logic [1:0] K_BRANCH = 2'b00;
    localparam logic [1:0] K_JAL    = 2'b01;
    localparam logic [1:0] K_JALR   = 2'b10;

    // Flush counter only needs to hold FLUSH_CYCLES; keep at least one bit.
    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       kind_q, kind_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      imm_q, imm_d;
    logic [31:0]      rs1_q, rs1_d;
    logic [31:0]      rs2_q, rs2_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic [31:0]      link_data_q, link_data_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
    logic [CNT_W-1:0] cnt_tk_q, cnt_tk_d;

    logic        cond_taken;
    logic        taken;
    logic        is_jump;
    logic [31:0] jalr_sum;
    logic [31:0] target;
    logic        target_misaligned;

    // Branch comparator on the latched operands (same funct3 meaning as the core).
    always_comb begin
        cond_taken = 1'b0;
        case (funct3_q)
            3'b000:  cond_taken = (rs1_q == rs2_q);
            3'b001:  cond_taken = (rs1_q != rs2_q);
            3'b100:  cond_taken = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  cond_taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  cond_taken = (rs1_q <  rs2_q);
            3'b111:  cond_taken = (rs1_q >= rs2_q);
            default: cond_taken = 1'b0;
        endcase
    end

    // Resolve taken/target for the latched request; kind 11 is never taken.
    always_comb begin
        is_jump  = (kind_q == K_JAL) || (kind_q == K_JALR);
        jalr_sum = rs1_q + imm_q;
        if (kind_q == K_BRANCH) begin
            taken = cond_taken;
        end else begin
            taken = is_jump;
        end
        if (kind_q == K_JALR) begin
            target = {jalr_sum[31:1], 1'b0};
        end else begin
            target = pc_q + imm_q;
        end
        target_misaligned = (target[1:0] != 2'b00);
    end

    // Next-state, request latching, statistics and flush countdown.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        funct3_d    = funct3_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        redir_pc_d  = redir_pc_q;
        link_data_d = link_data_q;
        fcnt_d      = fcnt_q;
        cnt_br_d    = cnt_br_q;
        cnt_tk_d    = cnt_tk_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d  = S_EVAL;
                    kind_d   = req_kind;
                    funct3_d = req_funct3;
                    pc_d     = req_pc;
                    imm_d    = req_imm;
                    rs1_d    = req_rs1;
                    rs2_d    = req_rs2;
                    // Link value is ready in EVAL, where link_valid pulses.
                    if ((req_kind == K_JAL) || (req_kind == K_JALR)) begin
                        link_data_d = req_pc + 32'd4;
                    end
                end
            end
            S_EVAL: begin
                if (kind_q == K_BRANCH) begin
                    cnt_br_d = cnt_br_q + CNT_W'(1);
                    if (taken) begin
                        cnt_tk_d = cnt_tk_q + CNT_W'(1);
                    end
                end
                if (taken && !target_misaligned) begin
                    state_d    = S_REDIRECT;
                    redir_pc_d = target;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIRECT: begin
                if (redir_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FLUSH;
                        fcnt_d  = FC_W'(FLUSH_CYCLES);
                    end
                end
            end
            S_FLUSH: begin
                if (fcnt_q <= FC_W'(1)) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kind_q      <= '0;
            funct3_q    <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            redir_pc_q  <= '0;
            link_data_q <= '0;
            fcnt_q      <= '0;
            cnt_br_q    <= '0;
            cnt_tk_q    <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            funct3_q    <= funct3_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            redir_pc_q  <= redir_pc_d;
            link_data_q <= link_data_d;
            fcnt_q      <= fcnt_d;
            cnt_br_q    <= cnt_br_d;
            cnt_tk_q    <= cnt_tk_d;
        end
    end

    // Outputs are registers or decodes of the registered state.
    always_comb begin
        req_ready    = (state_q == S_IDLE);
        redir_valid  = (state_q == S_REDIRECT);
        redir_pc     = redir_pc_q;
        flush        = (state_q == S_FLUSH);
        link_valid   = (state_q == S_EVAL) && is_jump;
        link_data    = link_data_q;
        misalign     = (state_q == S_EVAL) && taken && target_misaligned;
        cnt_branches = cnt_br_q;
        cnt_taken    = cnt_tk_q;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Testbench for branch_seq_ctrl: a FLUSH_CYCLES=2/CNT_W=32 instance and a
// FLUSH_CYCLES=0/CNT_W=3 instance share the request bus; sel picks which one
// receives req_valid and whose outputs are observed.
module tb_branch_seq_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    int          sel = 0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_kind = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_pc = '0, req_imm = '0, req_rs1 = '0, req_rs2 = '0;
    logic        redir_ready = 1'b1;

    logic a_req_valid, b_req_valid;
    assign a_req_valid = req_valid && (sel == 0);
    assign b_req_valid = req_valid && (sel == 1);

    logic        a_req_ready, a_redir_valid, a_flush, a_link_valid, a_misalign;
    logic [31:0] a_redir_pc, a_link_data, a_cnt_br, a_cnt_tk;
    logic [1:0]  a_state;
    logic        b_req_ready, b_redir_valid, b_flush, b_link_valid, b_misalign;
    logic [31:0] b_redir_pc, b_link_data;
    logic [2:0]  b_cnt_br, b_cnt_tk;
    logic [1:0]  b_state;

    branch_seq_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_kind(req_kind), .req_funct3(req_funct3), .req_pc(req_pc),
        .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .redir_valid(a_redir_valid), .redir_ready(redir_ready), .redir_pc(a_redir_pc),
        .flush(a_flush), .link_valid(a_link_valid), .link_data(a_link_data),
        .misalign(a_misalign), .cnt_branches(a_cnt_br), .cnt_taken(a_cnt_tk),
        .dbg_state(a_state)
    );

    branch_seq_ctrl #(.FLUSH_CYCLES(0), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_kind(req_kind), .req_funct3(req_funct3), .req_pc(req_pc),
        .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .redir_valid(b_redir_valid), .redir_ready(redir_ready), .redir_pc(b_redir_pc),
        .flush(b_flush), .link_valid(b_link_valid), .link_data(b_link_data),
        .misalign(b_misalign), .cnt_branches(b_cnt_br), .cnt_taken(b_cnt_tk),
        .dbg_state(b_state)
    );

    // Observed outputs of the selected instance.
    logic        o_req_ready, o_redir_valid, o_flush, o_link_valid, o_misalign;
    logic [31:0] o_redir_pc, o_link_data, o_cnt_br, o_cnt_tk;
    always_comb begin
        o_req_ready   = (sel == 1) ? b_req_ready   : a_req_ready;
        o_redir_valid = (sel == 1) ? b_redir_valid : a_redir_valid;
        o_flush       = (sel == 1) ? b_flush       : a_flush;
        o_link_valid  = (sel == 1) ? b_link_valid  : a_link_valid;
        o_misalign    = (sel == 1) ? b_misalign    : a_misalign;
        o_redir_pc    = (sel == 1) ? b_redir_pc    : a_redir_pc;
        o_link_data   = (sel == 1) ? b_link_data   : a_link_data;
        o_cnt_br      = (sel == 1) ? {29'd0, b_cnt_br} : a_cnt_br;
        o_cnt_tk      = (sel == 1) ? {29'd0, b_cnt_tk} : a_cnt_tk;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_br[2];
    logic [31:0] m_tk[2];
    int b_flush_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Redirect monitor: every handshake must match the oldest expected target.
    always @(negedge clk) begin
        if (!rst && o_redir_valid && redir_ready) begin
            if (exp_q.size() == 0) begin
                check("redir_unexpected", 32'd1, 32'd0);
            end else begin
                check("sb_redir_pc", o_redir_pc, exp_q.pop_front());
            end
        end
        if (b_flush) b_flush_seen++;
    end

    // Reference model: returns {taken, target}.
    function automatic logic [32:0] model(input logic [1:0] kind, input logic [2:0] f3,
                                          input logic [31:0] pc, input logic [31:0] imm,
                                          input logic [31:0] rs1, input logic [31:0] rs2);
        logic        t;
        logic [31:0] tg;
        t  = 1'b0;
        tg = pc + imm;
        if (kind == 2'b00) begin
            if (f3 == 3'b000)      t = (rs1 == rs2);
            else if (f3 == 3'b001) t = (rs1 != rs2);
            else if (f3 == 3'b100) t = (int'(rs1) < int'(rs2));
            else if (f3 == 3'b101) t = !(int'(rs1) < int'(rs2));
            else if (f3 == 3'b110) t = (rs1 < rs2);
            else if (f3 == 3'b111) t = !(rs1 < rs2);
        end else if (kind == 2'b01) begin
            t = 1'b1;
        end else if (kind == 2'b10) begin
            t  = 1'b1;
            tg = (rs1 + imm) & 32'hFFFF_FFFE;
        end
        return {t, tg};
    endfunction

    // ---------------- driver ----------------
    // Called and returns at a negedge. stall = cycles redir_ready stays low.
    task automatic send(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int stall);
        logic [32:0] r;
        logic        taken, jump, mis;
        logic [31:0] tgt, mask;
        int          f, waited;
        r     = model(kind, f3, pc, imm, rs1, rs2);
        taken = r[32];
        tgt   = r[31:0];
        jump  = (kind == 2'b01) || (kind == 2'b10);
        mis   = taken && (tgt[1:0] != 2'b00);
        f     = (sel == 1) ? 0 : 2;
        mask  = (sel == 1) ? 32'h7 : 32'hFFFF_FFFF;
        waited = 0;
        while (!o_req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_timeout", {31'd0, o_req_ready}, 32'd1);
        redir_ready = (stall == 0);
        req_valid = 1'b1; req_kind = kind; req_funct3 = f3;
        req_pc = pc; req_imm = imm; req_rs1 = rs1; req_rs2 = rs2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        // cycle 1: EVAL
        @(negedge clk);
        check("eval_ready", {31'd0, o_req_ready}, 32'd0);
        check("link_valid", {31'd0, o_link_valid}, {31'd0, jump});
        if (jump) check("link_data", o_link_data, pc + 32'd4);
        check("misalign", {31'd0, o_misalign}, {31'd0, mis});
        if (kind == 2'b00) begin
            m_br[sel] = (m_br[sel] + 1) & mask;
            if (taken) m_tk[sel] = (m_tk[sel] + 1) & mask;
        end
        if (taken && !mis) exp_q.push_back(tgt);
        // cycle 2
        @(negedge clk);
        check("cnt_branches", o_cnt_br, m_br[sel]);
        check("cnt_taken", o_cnt_tk, m_tk[sel]);
        if (taken && !mis) begin
            for (int c = 0; c < stall; c++) begin
                check("stall_valid", {31'd0, o_redir_valid}, 32'd1);
                check("stall_pc", o_redir_pc, tgt);
                check("stall_flush", {31'd0, o_flush}, 32'd0);
                @(posedge clk);
                #1 if (c == stall - 1) redir_ready = 1'b1;
                @(negedge clk);
            end
            check("hs_valid", {31'd0, o_redir_valid}, 32'd1);
            check("hs_pc", o_redir_pc, tgt);
            check("hs_flush", {31'd0, o_flush}, 32'd0);
            for (int c = 0; c < f; c++) begin
                @(negedge clk);
                check("flush_on", {31'd0, o_flush}, 32'd1);
                check("flush_ready", {31'd0, o_req_ready}, 32'd0);
                check("flush_redir", {31'd0, o_redir_valid}, 32'd0);
            end
            @(negedge clk);
            check("post_flush", {31'd0, o_flush}, 32'd0);
            check("post_ready", {31'd0, o_req_ready}, 32'd1);
        end else begin
            check("nt_ready", {31'd0, o_req_ready}, 32'd1);
            check("nt_redir", {31'd0, o_redir_valid}, 32'd0);
            check("nt_flush", {31'd0, o_flush}, 32'd0);
        end
    endtask

    task automatic check_reset_values();
        check("rst_ready", {31'd0, o_req_ready}, 32'd1);
        check("rst_redir_valid", {31'd0, o_redir_valid}, 32'd0);
        check("rst_redir_pc", o_redir_pc, 32'd0);
        check("rst_flush", {31'd0, o_flush}, 32'd0);
        check("rst_link_valid", {31'd0, o_link_valid}, 32'd0);
        check("rst_link_data", o_link_data, 32'd0);
        check("rst_misalign", {31'd0, o_misalign}, 32'd0);
        check("rst_cnt_br", o_cnt_br, 32'd0);
        check("rst_cnt_tk", o_cnt_tk, 32'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0] f3_tab[8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        m_br[0] = 0; m_tk[0] = 0; m_br[1] = 0; m_tk[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Directed cases on the FLUSH_CYCLES=2 instance.
        send(2'b00, 3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 0);                   // beq taken
        check("beq_cnt_br", o_cnt_br, 32'd1);
        check("beq_cnt_tk", o_cnt_tk, 32'd1);
        send(2'b00, 3'b100, 32'h200, 32'h20, 32'hFFFF_FFFF, 32'd1, 0);           // blt taken
        send(2'b00, 3'b110, 32'h200, 32'h20, 32'hFFFF_FFFF, 32'd1, 0);           // bltu not taken
        send(2'b10, 3'b000, 32'h300, 32'h0, 32'h203, 32'd0, 0);                  // jalr misaligned
        check("jalr_cnt_br", o_cnt_br, 32'd3);
        send(2'b01, 3'b000, 32'h1000, 32'h10, 32'd0, 32'd0, 5);                  // jal, stalled
        send(2'b00, 3'b001, 32'h8, 32'hFFFF_FFF0, 32'd1, 32'd2, 0);              // bne, wraps
        send(2'b00, 3'b101, 32'h40, 32'h8, 32'h8000_0000, 32'd0, 0);             // bge not taken
        send(2'b00, 3'b111, 32'h40, 32'h8, 32'h8000_0000, 32'd0, 1);             // bgeu taken
        send(2'b00, 3'b010, 32'h40, 32'h8, 32'd3, 32'd3, 0);                     // funct3 010
        send(2'b00, 3'b000, 32'h100, 32'h42, 32'd7, 32'd7, 0);                   // misaligned branch
        send(2'b11, 3'b000, 32'h100, 32'h40, 32'd7, 32'd7, 0);                   // reserved kind
        send(2'b10, 3'b000, 32'h0, 32'h11, 32'h3FF, 32'd0, 0);                   // jalr aligned

        // Random mix.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] rs1, rs2, imm;
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 1) == 1) ? rs1 : $urandom;
            imm = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 3) == 0) imm[1:0] = 2'($urandom_range(1, 3));
            send(2'($urandom_range(0, 3)), f3_tab[$urandom_range(0, 7)],
                 {20'd0, 10'($urandom_range(0, 1023)), 2'b00}, imm, rs1, rs2,
                 $urandom_range(0, 2));
        end

        // Reset while in REDIRECT.
        redir_ready = 1'b0;
        req_valid = 1'b1; req_kind = 2'b01; req_pc = 32'h40; req_imm = 32'h80;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_redir", {31'd0, o_redir_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        m_br[0] = 0; m_tk[0] = 0; m_br[1] = 0; m_tk[1] = 0;
        check_reset_values();
        redir_ready = 1'b1;
        @(negedge clk);
        check("rst_still_idle", {31'd0, o_redir_valid}, 32'd0);

        // FLUSH_CYCLES=0, CNT_W=3 instance.
        sel = 1;
        @(negedge clk);
        send(2'b00, 3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 0);
        send(2'b01, 3'b000, 32'h1000, 32'h10, 32'd0, 32'd0, 2);
        for (int i = 0; i < 6; i++) begin
            send(2'b00, f3_tab[$urandom_range(0, 7)], 32'h200, 32'h10,
                 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), 0);
        end
        check("cnt_full", o_cnt_br, 32'd7);
        send(2'b00, 3'b001, 32'h200, 32'h10, 32'd1, 32'd1, 0);
        check("cnt_wrap", o_cnt_br, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        check("b_flush_never", b_flush_seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
